encout_elc_in_sync_mc: RTL and testbench
========================================

Name: encout_elc_in_sync_mc

Overview:
- Multi-channel successor to the single-channel ELC input synchroniser in the encoder-output (ENCOUT) subsystem.
- Synchronises NCH asynchronous ELC event inputs into the w_elc_in_act_clk domain and detects per-channel rising, falling or both edges.
- Emits a one-cycle pulse per detected edge.
- Keeps a saturating per-channel event counter with a sticky overflow flag for software or the ENCOUT sequencer.

Parameters:
- NCH, 4, number of ELC input channels (1..16).
- SYNC_STAGES, 3, synchroniser flop depth per channel (2..4).
- CNT_W, 8, event counter width per channel (1..16).
- FILT_LEN, 4, glitch-filter stable-cycle count; used only with the optional feature (2..15).

Ports:
- w_elc_in_act_clk  in  1  block clock.
- w_elc_in_act_resetn  in  1  reset; asynchronous, active-low.
- i_elc_in  in  NCH  asynchronous ELC event inputs.
- i_en  in  1  global detect enable.
- i_edge_sel  in  2*NCH  per channel {ch*2+1:ch*2}: 00 off, 01 rise, 10 fall, 11 both.
- i_cnt_clr  in  NCH  per-channel counter clear, one-cycle pulse.
- i_ovf_clr  in  NCH  per-channel overflow clear.
- o_elc_in_sync  out  NCH  one-cycle edge pulse per channel.
- o_evt_cnt  out  NCH*CNT_W  per-channel event count; channel ch at [ch*CNT_W +: CNT_W].
- o_ovf  out  NCH  sticky counter-overflow flag.
- o_ready  out  1  high once priming after reset is complete.

Behaviour:
- Reset (async assert, sync deassert handled upstream): all sync flops, history, counters and o_ovf are 0; o_elc_in_sync = 0; o_ready = 0.
- Priming FSM, shared by all channels:
  - States PRIME and RUN. PRIME is entered on reset.
  - A PRIME counter runs SYNC_STAGES+1 cycles, then moves to RUN and sets o_ready = 1.
  - In PRIME the history register tracks the synchronised value, but no pulse is generated. A high input at reset release therefore produces no spurious rising edge.
  - RUN is left only by reset.
- Per channel, every cycle:
  - The sync chain shifts i_elc_in.
  - Synchronised value s = stage[SYNC_STAGES-1]; previous value h <= s.
  - rise = s & ~h; fall = ~s & h.
  - Pulse = RUN & i_en & ((sel[0] & rise) | (sel[1] & fall)).
  - o_elc_in_sync is registered: it asserts one cycle after the edge is seen at s.
- Latency:
  - An input transition settled before clock edge k gives a pulse high in cycle k+SYNC_STAGES+1.
  - Exactly one cycle wide per edge.
  - Input pulses shorter than one clock period may be missed; this is not guaranteed.
- The history register always updates, including when i_en = 0 or sel = 00. Enabling detection never creates a pulse from stale history.
- i_edge_sel and i_en take effect from the cycle they are sampled; there is no holding register.
- Counter, on the same cycle as the pulse register:
  - pulse & ~clr: cnt + 1.
  - At 2^CNT_W - 1 the counter holds, and o_ovf sets on the attempted increment.
  - clr & pulse: cnt = 1.
  - clr alone: cnt = 0.
  - o_ovf is cleared only by i_ovf_clr; if a set and a clear coincide, set wins.
- Channels are fully independent; simultaneous edges on all channels are all pulsed and counted in the same cycle.
- Reset mid-operation: everything returns to reset values immediately, and PRIME is re-run.

Optional Feature:
- Macro ENCOUT_ELC_IN_FILT_EN.
- Defined:
  - A per-channel filter sits between the sync chain and edge detect.
  - Filtered value f changes only after s has differed from f for FILT_LEN consecutive cycles.
  - The filter counter resets to 0 whenever s == f.
  - f resets to 0; during PRIME, f loads s directly.
  - Latency grows by FILT_LEN cycles; glitches shorter than FILT_LEN cycles are suppressed.
- Undefined: f = s, FILT_LEN is ignored, and there is no filter logic.

Decomposition:
- Package encout_elc_pkg contains:
  - edge_sel_e enum (ESEL_OFF, ESEL_RISE, ESEL_FALL, ESEL_BOTH).
  - prime_state_e enum (PRIME, RUN).
  - Parameter range-check constants.
- Sub-module encout_elc_ch: one channel's sync chain, optional filter, history, pulse and counter/ovf.
- The top level holds the priming FSM and a generate loop over NCH channels.

Test Plan:
- Reset release with i_elc_in = 4'b1111 and sel = 01 on all channels -> no o_elc_in_sync pulse; o_ready = 1 after 4 cycles (SYNC_STAGES = 3).
- ch0 sel = 01 and i_elc_in[0] 0->1 in RUN -> o_elc_in_sync[0] high for exactly 1 cycle, 4 cycles later; o_evt_cnt ch0 = 1. Then 1->0 -> no pulse.
- ch1 sel = 11 with 3 full toggles -> 6 pulses, cnt ch1 = 6. ch2 sel = 00 with the same stimulus -> 0 pulses, cnt = 0.
- CNT_W = 8 with 256 rising edges on ch3 -> cnt holds at 255 and o_ovf[3] = 1. i_ovf_clr[3] together with a further edge -> o_ovf[3] stays 1.
- i_cnt_clr[0] coincident with an ch0 pulse -> cnt ch0 = 1. Clear alone -> 0.
- With ENCOUT_ELC_IN_FILT_EN and FILT_LEN = 4: a 3-cycle high glitch -> no pulse; a 5-cycle high -> one pulse at latency 8.

Source files
------------

// File: rtl/encout_elc_pkg.sv
// Shared types and parameter limits for the multi-channel ELC input synchroniser.
package encout_elc_pkg;

  typedef enum logic [1:0] {
    ESEL_OFF  = 2'b00,
    ESEL_RISE = 2'b01,
    ESEL_FALL = 2'b10,
    ESEL_BOTH = 2'b11
  } edge_sel_e;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } prime_state_e;

  localparam int NCH_MIN   = 1;
  localparam int NCH_MAX   = 16;
  localparam int SYNC_MIN  = 2;
  localparam int SYNC_MAX  = 4;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 16;
  localparam int FILT_MIN  = 2;
  localparam int FILT_MAX  = 15;

endpackage

// File: rtl/encout_elc_ch.sv
// One ELC channel: sync chain, optional glitch filter (ENCOUT_ELC_IN_FILT_EN),
// edge history, registered pulse and saturating event counter with sticky overflow.
module encout_elc_ch
  import encout_elc_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int CNT_W       = 8,
  parameter int FILT_LEN    = 4
) (
  input  logic             w_elc_in_act_clk,
  input  logic             w_elc_in_act_resetn,
  input  logic             elc_in_i,
  input  logic             run_i,
  input  logic             en_i,
  input  logic [1:0]       sel_i,
  input  logic             cnt_clr_i,
  input  logic             ovf_clr_i,
  output logic             pulse_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX ||
      CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX ||
      FILT_LEN < FILT_MIN || FILT_LEN > FILT_MAX) begin : g_param_err
    $error("encout_elc_ch: parameter out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, f, hist_d, h_q;
  logic                   pulse_d, pulse_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q;
  logic                   ovf_d, ovf_q;
  logic                   rise_en, fall_en;
  edge_sel_e              sel_e;

  always_ff @(posedge w_elc_in_act_clk or negedge w_elc_in_act_resetn) begin
    if (!w_elc_in_act_resetn) sync_q <= '0;
    else                      sync_q <= {sync_q[SYNC_STAGES-2:0], elc_in_i};
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef ENCOUT_ELC_IN_FILT_EN
  logic       f_q;
  logic [3:0] fcnt_q;

  always_ff @(posedge w_elc_in_act_clk or negedge w_elc_in_act_resetn) begin
    if (!w_elc_in_act_resetn) begin
      f_q    <= 1'b0;
      fcnt_q <= '0;
    end else if (!run_i) begin
      f_q    <= s;
      fcnt_q <= '0;
    end else if (s == f_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == 4'(FILT_LEN - 1)) begin
      f_q    <= s;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 4'd1;
    end
  end

  assign f = f_q;
  // While priming, history follows s together with f so RUN starts with h == f.
  assign hist_d = run_i ? f_q : s;
`else
  assign f      = s;
  assign hist_d = s;
`endif

  always_ff @(posedge w_elc_in_act_clk or negedge w_elc_in_act_resetn) begin
    if (!w_elc_in_act_resetn) h_q <= 1'b0;
    else                      h_q <= hist_d;
  end

  assign sel_e   = edge_sel_e'(sel_i);
  assign rise_en = (sel_e == ESEL_RISE) || (sel_e == ESEL_BOTH);
  assign fall_en = (sel_e == ESEL_FALL) || (sel_e == ESEL_BOTH);
  assign pulse_d = run_i & en_i & ((rise_en & f & ~h_q) | (fall_en & ~f & h_q));

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q & ~ovf_clr_i;
    if (cnt_clr_i) begin
      cnt_d = CNT_W'(pulse_d);
    end else if (pulse_d) begin
      if (cnt_q == '1) ovf_d = 1'b1;
      else             cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge w_elc_in_act_clk or negedge w_elc_in_act_resetn) begin
    if (!w_elc_in_act_resetn) begin
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pulse_o = pulse_q;
  assign cnt_o   = cnt_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/encout_elc_in_sync_mc.sv
// Multi-channel ELC input synchroniser: shared priming FSM plus NCH channel instances.
// Optional glitch filter enabled by defining ENCOUT_ELC_IN_FILT_EN.
module encout_elc_in_sync_mc
  import encout_elc_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 3,
  parameter int CNT_W       = 8,
  parameter int FILT_LEN    = 4
) (
  input  logic                 w_elc_in_act_clk,
  input  logic                 w_elc_in_act_resetn,
  input  logic [NCH-1:0]       i_elc_in,
  input  logic                 i_en,
  input  logic [2*NCH-1:0]     i_edge_sel,
  input  logic [NCH-1:0]       i_cnt_clr,
  input  logic [NCH-1:0]       i_ovf_clr,
  output logic [NCH-1:0]       o_elc_in_sync,
  output logic [NCH*CNT_W-1:0] o_evt_cnt,
  output logic [NCH-1:0]       o_ovf,
  output logic                 o_ready
);

  if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_param_err
    $error("encout_elc_in_sync_mc: NCH out of range");
  end

  localparam logic [0:0] ST_PRIME = PRIME;
  localparam logic [0:0] ST_RUN   = RUN;

  logic [0:0] state_q, state_d;
  logic [2:0] prime_cnt_q, prime_cnt_d;
  logic       run;

  // PRIME lasts SYNC_STAGES+1 cycles so the chains and history hold real input values.
  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    if (state_q == ST_PRIME) begin
      if (prime_cnt_q == 3'(SYNC_STAGES)) begin
        state_d     = ST_RUN;
        prime_cnt_d = '0;
      end else begin
        prime_cnt_d = prime_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge w_elc_in_act_clk or negedge w_elc_in_act_resetn) begin
    if (!w_elc_in_act_resetn) begin
      state_q     <= ST_PRIME;
      prime_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
    end
  end

  assign run     = (state_q == ST_RUN);
  assign o_ready = run;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    encout_elc_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W),
      .FILT_LEN   (FILT_LEN)
    ) u_ch (
      .w_elc_in_act_clk   (w_elc_in_act_clk),
      .w_elc_in_act_resetn(w_elc_in_act_resetn),
      .elc_in_i           (i_elc_in[ch]),
      .run_i              (run),
      .en_i               (i_en),
      .sel_i              (i_edge_sel[ch*2 +: 2]),
      .cnt_clr_i          (i_cnt_clr[ch]),
      .ovf_clr_i          (i_ovf_clr[ch]),
      .pulse_o            (o_elc_in_sync[ch]),
      .cnt_o              (o_evt_cnt[ch*CNT_W +: CNT_W]),
      .ovf_o              (o_ovf[ch])
    );
  end

endmodule

// File: tb/tb_encout_elc_in_sync_mc.sv
// Directed self-checking bench for encout_elc_in_sync_mc (NCH=4, SYNC_STAGES=3, CNT_W=8).
module tb_encout_elc_in_sync_mc;

`ifdef ENCOUT_ELC_IN_FILT_EN
  localparam int LAT = 8;
  localparam int HP  = 5;
`else
  localparam int LAT = 4;
  localparam int HP  = 2;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  in_v, cnt_clr, ovf_clr;
  logic        en;
  logic [7:0]  sel;
  logic [3:0]  sync_o, ovf_o;
  logic [31:0] cnt_o;
  logic        rdy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  encout_elc_in_sync_mc dut (
    .w_elc_in_act_clk   (clk),
    .w_elc_in_act_resetn(rstn),
    .i_elc_in           (in_v),
    .i_en               (en),
    .i_edge_sel         (sel),
    .i_cnt_clr          (cnt_clr),
    .i_ovf_clr          (ovf_clr),
    .o_elc_in_sync      (sync_o),
    .o_evt_cnt          (cnt_o),
    .o_ovf              (ovf_o),
    .o_ready            (rdy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] cnt_of(input int ch);
    return cnt_o[ch*8 +: 8];
  endfunction

  task automatic run_or(input int n, output logic [3:0] acc);
    acc = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      acc = acc | sync_o;
    end
  endtask

  task automatic watch(input int ch, input int n, output int first, output int np);
    first = 0;
    np    = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (sync_o[ch]) begin
        np++;
        if (first == 0) first = i;
      end
    end
  endtask

  logic [3:0] acc;
  int first, np, np1, np2;

  initial begin
    in_v = 4'hF; en = 1'b1; sel = 8'h55; cnt_clr = '0; ovf_clr = '0; rstn = 1'b0;
    tick(); tick();
    chk("rst_ready", 32'(rdy), 0);
    chk("rst_sync", 32'(sync_o), 0);
    chk("rst_cnt", cnt_o, 0);
    chk("rst_ovf", 32'(ovf_o), 0);

    rstn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("prime_ready_%0d", i), 32'(rdy), 32'(i == 4));
      chk($sformatf("prime_nopulse_%0d", i), 32'(sync_o), 0);
    end
    run_or(LAT + 2, acc);
    chk("high_at_release_nopulse", 32'(acc), 0);
    chk("high_at_release_cnt", cnt_o, 0);

    in_v = 4'h0;
    run_or(LAT + 2, acc);
    chk("fall_sel_rise_none", 32'(acc), 0);

    in_v[0] = 1'b1;
    watch(0, LAT + 4, first, np);
    chk("ch0_rise_latency", 32'(first), LAT);
    chk("ch0_rise_width", 32'(np), 1);
    chk("ch0_cnt_1", 32'(cnt_of(0)), 1);
    in_v[0] = 1'b0;
    watch(0, LAT + 4, first, np);
    chk("ch0_fall_none", 32'(np), 0);

    sel = 8'b01_00_11_01;
    np1 = 0; np2 = 0;
    for (int t = 0; t < 6; t++) begin
      in_v[1] = ~in_v[1];
      in_v[2] = ~in_v[2];
      for (int i = 0; i < LAT + 2; i++) begin
        tick();
        np1 += int'(sync_o[1]);
        np2 += int'(sync_o[2]);
      end
    end
    chk("ch1_both_pulses", 32'(np1), 6);
    chk("ch2_off_pulses", 32'(np2), 0);
    chk("ch1_cnt_6", 32'(cnt_of(1)), 6);
    chk("ch2_cnt_0", 32'(cnt_of(2)), 0);

    en = 1'b0;
    in_v[0] = 1'b1;
    run_or(LAT + 2, acc);
    chk("en0_no_pulse", 32'(acc[0]), 0);
    en = 1'b1;
    run_or(LAT + 2, acc);
    chk("enable_stale_none", 32'(acc[0]), 0);
    chk("en0_cnt_hold", 32'(cnt_of(0)), 1);
    in_v[0] = 1'b0;
    run_or(LAT + 2, acc);

    in_v[0] = 1'b1;
    repeat (LAT - 1) tick();
    cnt_clr[0] = 1'b1;
    tick();
    cnt_clr[0] = 1'b0;
    chk("clr_pulse_sync", 32'(sync_o[0]), 1);
    chk("clr_with_pulse_cnt", 32'(cnt_of(0)), 1);
    cnt_clr[0] = 1'b1;
    tick();
    cnt_clr[0] = 1'b0;
    chk("clr_alone_cnt", 32'(cnt_of(0)), 0);
    in_v[0] = 1'b0;
    run_or(LAT + 2, acc);

    for (int e = 0; e < 255; e++) begin
      in_v[3] = 1'b1; repeat (HP) tick();
      in_v[3] = 1'b0; repeat (HP) tick();
    end
    repeat (LAT + 2) tick();
    chk("ch3_cnt_255", 32'(cnt_of(3)), 255);
    chk("ch3_ovf_not_yet", 32'(ovf_o[3]), 0);
    in_v[3] = 1'b1; repeat (HP) tick();
    in_v[3] = 1'b0; repeat (LAT + 2) tick();
    chk("ch3_cnt_sat", 32'(cnt_of(3)), 255);
    chk("ch3_ovf_set", 32'(ovf_o[3]), 1);

    in_v[3] = 1'b1;
    repeat (LAT - 1) tick();
    ovf_clr[3] = 1'b1;
    tick();
    ovf_clr[3] = 1'b0;
    chk("ovf_coinc_pulse", 32'(sync_o[3]), 1);
    chk("ovf_set_wins", 32'(ovf_o[3]), 1);
    tick();
    chk("ovf_sticky", 32'(ovf_o[3]), 1);
    ovf_clr[3] = 1'b1;
    tick();
    ovf_clr[3] = 1'b0;
    chk("ovf_clr_alone", 32'(ovf_o[3]), 0);
    chk("ch3_cnt_after_clr", 32'(cnt_of(3)), 255);
    in_v[3] = 1'b0;
    run_or(LAT + 2, acc);

    sel  = 8'hFF;
    in_v = 4'hF;
    repeat (LAT) tick();
    chk("all_ch_simul", 32'(sync_o), 32'h0000_000F);
    tick();
    chk("all_ch_width", 32'(sync_o), 0);
    chk("all_ch_cnt", cnt_o, 32'hFF_01_07_01);
    chk("all_ch_ovf", 32'(ovf_o), 32'h8);

    rstn = 1'b0;
    #1;
    chk("midrst_ready", 32'(rdy), 0);
    chk("midrst_cnt", cnt_o, 0);
    chk("midrst_ovf", 32'(ovf_o), 0);
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    chk("reprime_ready_3", 32'(rdy), 0);
    tick();
    chk("reprime_ready_4", 32'(rdy), 1);
    run_or(LAT + 2, acc);
    chk("reprime_nopulse", 32'(acc), 0);

`ifdef ENCOUT_ELC_IN_FILT_EN
    sel  = 8'h55;
    in_v = 4'h0;
    run_or(LAT + 2, acc);
    in_v[0] = 1'b1;
    repeat (3) tick();
    in_v[0] = 1'b0;
    watch(0, LAT + 6, first, np);
    chk("filt_glitch3_none", 32'(np), 0);
    in_v[0] = 1'b1;
    watch(0, 5, first, np1);
    in_v[0] = 1'b0;
    watch(0, LAT + 4, first, np);
    chk("filt_hi5_early_none", 32'(np1), 0);
    chk("filt_hi5_one_pulse", 32'(np), 1);
    chk("filt_hi5_latency", 32'(first + 5), 8);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
